// File: rtl/clocking_delay_pkg.sv
// rtl/clocking_delay_pkg.sv - shared types and defaults for the delay config/response handshake
// Purpose: handshake bundle structs, responder state encoding, default timing constants.
// Ports: none (package).
package clocking_delay_pkg;

  localparam int DELAY_WIDTH_DFLT   = 9;
  localparam int VTC_CYCLES_DFLT    = 8;
  localparam int SETTLE_CYCLES_DFLT = 16;

  typedef struct packed {
    logic                        load;
    logic [DELAY_WIDTH_DFLT-1:0] value;
  } t_delay_config;

  typedef struct packed {
    logic                        load_ack;
    logic [DELAY_WIDTH_DFLT-1:0] value;
    logic                        sync_value;
  } t_delay_response;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VTC_OFF,
    ST_LOAD,
    ST_SETTLE,
    ST_ACK,
    ST_WAIT_RELEASE
  } t_delay_responder_state;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchroniser for a single asynchronous bit
// Purpose: shift an asynchronous input through STAGES flops into the clk domain.
// Ports: clk (in), reset_n (in, async active-low), d (in, async bit), q (out, synchronised bit).
module sync_bit #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/delay_config_responder.sv
// rtl/delay_config_responder.sv - sequences tap loads into a variable delay element and acks them
// Purpose: on a load request, drop VT compensation, strobe the (clamped) tap into the delay element,
//   let it settle, restore VT compensation, pulse load_ack, then wait for the request to be released.
//   Also resynchronises the delayed data sample into the measurement clock domain.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   delay_config__load/__value      request level and requested tap
//   delay_response__load_ack        one-cycle ack pulse
//   delay_response__value           registered tap reported by the delay element
//   delay_response__sync_value      data_in after SYNC_STAGES flops
//   dly__load/__cntvalue/__en_vtc   controls to the delay element
//   dly__cntvalueout                tap reported by the delay element
//   data_in                         asynchronous delayed sample
module delay_config_responder
  import clocking_delay_pkg::*;
#(
  parameter int DELAY_WIDTH   = DELAY_WIDTH_DFLT,
  parameter int MAX_TAPS      = 511,
  parameter int VTC_CYCLES    = VTC_CYCLES_DFLT,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DFLT,
  parameter int SYNC_STAGES   = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   delay_config__load,
  input  logic [DELAY_WIDTH-1:0] delay_config__value,
  output logic                   delay_response__load_ack,
  output logic [DELAY_WIDTH-1:0] delay_response__value,
  output logic                   delay_response__sync_value,
  output logic                   dly__load,
  output logic [DELAY_WIDTH-1:0] dly__cntvalue,
  output logic                   dly__en_vtc,
  input  logic [DELAY_WIDTH-1:0] dly__cntvalueout,
  input  logic                   data_in
);

  localparam int CNT_MAX = max_int(VTC_CYCLES, SETTLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]       VTC_LAST    = CNT_W'(VTC_CYCLES - 1);
  localparam logic [CNT_W-1:0]       SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DELAY_WIDTH-1:0] MAX_TAP_V   = DELAY_WIDTH'(MAX_TAPS);

  t_delay_responder_state state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DELAY_WIDTH-1:0] cntvalue_q, cntvalue_d;
  logic [DELAY_WIDTH-1:0] value_q;
  logic                   en_vtc_q, en_vtc_d;
  logic                   dly_load_q, dly_load_d;
  logic                   load_ack_q, load_ack_d;
  logic [DELAY_WIDTH-1:0] clamped_value;

  assign clamped_value = (delay_config__value > MAX_TAP_V) ? MAX_TAP_V : delay_config__value;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cntvalue_d = cntvalue_q;
    en_vtc_d   = en_vtc_q;
    dly_load_d = 1'b0;
    load_ack_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        en_vtc_d = 1'b1;
        cnt_d    = '0;
        if (delay_config__load) begin
          cntvalue_d = clamped_value;
          en_vtc_d   = 1'b0;
          state_d    = ST_VTC_OFF;
        end
      end
      ST_VTC_OFF: begin
        // The load strobe is registered so it is high exactly while in LOAD.
        if (cnt_q == VTC_LAST) begin
          cnt_d      = '0;
          dly_load_d = 1'b1;
          state_d    = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d    = '0;
          en_vtc_d = 1'b1;
          state_d  = ST_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACK: begin
        load_ack_d = 1'b1;
        state_d    = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        // Requiring a low cycle here keeps a held-high request from reloading.
        if (!delay_config__load) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cntvalue_q <= '0;
      en_vtc_q   <= 1'b1;
      dly_load_q <= 1'b0;
      load_ack_q <= 1'b0;
      value_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cntvalue_q <= cntvalue_d;
      en_vtc_q   <= en_vtc_d;
      dly_load_q <= dly_load_d;
      load_ack_q <= load_ack_d;
      value_q    <= dly__cntvalueout;
    end
  end

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync_data (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (data_in),
    .q      (delay_response__sync_value)
  );

  assign delay_response__load_ack = load_ack_q;
  assign delay_response__value    = value_q;
  assign dly__load                = dly_load_q;
  assign dly__cntvalue            = cntvalue_q;
  assign dly__en_vtc              = en_vtc_q;

endmodule
